// File: rtl/uart_cmd_host_if.sv
// Signal bundle between the UART command host and the controller / serial lines it serves.
interface uart_cmd_host_if;
  logic        send_acq;
  logic        send_debug;
  logic [7:0]  trigger;
  logic [12:0] threshold;
  logic [23:0] samples_after;
  logic [23:0] samples_before;
  logic        uart_rx;
  logic        uart_tx;
  logic        busy;
  logic        tx_done;
  logic [15:0] rx_word;
  logic        rx_word_valid;
  logic        rx_frame_err;
  logic [15:0] rx_word_count;

  modport master (
    output send_acq, send_debug, trigger, threshold, samples_after, samples_before, uart_rx,
    input  uart_tx, busy, tx_done, rx_word, rx_word_valid, rx_frame_err, rx_word_count
  );

  modport slave (
    input  send_acq, send_debug, trigger, threshold, samples_after, samples_before, uart_rx,
    output uart_tx, busy, tx_done, rx_word, rx_word_valid, rx_frame_err, rx_word_count
  );
endinterface

// File: rtl/uart_cmd_host.sv
// Host side of the acquisition UART link: sends the 'A' command packet or the 'S' debug byte,
// and assembles the 2-byte response words coming back on uart_rx (8N1, LSB first).
module uart_cmd_host #(
  parameter int CLK           = 60,
  parameter int UART_SPEED    = 921600,
  parameter int TIMEOUT_BYTES = 4
) (
  input logic        clk_PSRAM,
  input logic        rst,
  uart_cmd_host_if.slave host
);

  localparam int DelayFrames   = (CLK * 1_000_000) / UART_SPEED;
  localparam int CntW          = $clog2(DelayFrames + 1);
  localparam int TimeoutCycles = TIMEOUT_BYTES * 10 * DelayFrames;
  localparam int ToW           = $clog2(TimeoutCycles + 1);

  localparam logic [CntW-1:0] BitLast    = CntW'(DelayFrames - 1);
  localparam logic [CntW-1:0] BitPreLast = CntW'(DelayFrames - 2);
  localparam logic [CntW-1:0] BitHalf    = CntW'(DelayFrames / 2);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [ToW-1:0]  ToLast     = ToW'(TimeoutCycles - 1);
  localparam logic [ToW-1:0]  ToOne      = ToW'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_e;

  txState_e        txState_q;
  logic [CntW-1:0] txCnt_q;
  logic [2:0]      txBit_q;
  logic [7:0]      txShift_q;
  logic [71:0]     txPkt_q;
  logic [3:0]      txLeft_q;

  // txShift_q holds the byte on the wire, txPkt_q the bytes still to follow, txLeft_q their count.
  always_ff @(posedge clk_PSRAM) begin
    if (rst) begin
      txState_q    <= TX_IDLE;
      txCnt_q      <= '0;
      txBit_q      <= '0;
      txShift_q    <= '0;
      txPkt_q      <= '0;
      txLeft_q     <= '0;
      host.uart_tx <= 1'b1;
      host.busy    <= 1'b0;
      host.tx_done <= 1'b0;
    end else begin
      host.tx_done <= 1'b0;
      unique case (txState_q)
        TX_IDLE: begin
          if (host.send_acq || host.send_debug) begin
            txState_q    <= TX_START;
            txCnt_q      <= '0;
            host.busy    <= 1'b1;
            host.uart_tx <= 1'b0;
            if (host.send_acq) begin
              txShift_q <= 8'h41;
              txPkt_q   <= {host.trigger, 3'b000, host.threshold,
                            host.samples_after, host.samples_before};
              txLeft_q  <= 4'd9;
            end else begin
              txShift_q <= 8'h53;
              txPkt_q   <= '0;
              txLeft_q  <= 4'd0;
            end
          end
        end
        TX_START: begin
          if (txCnt_q == BitLast) begin
            txCnt_q      <= '0;
            txBit_q      <= '0;
            host.uart_tx <= txShift_q[0];
            txState_q    <= TX_DATA;
          end else begin
            txCnt_q <= txCnt_q + CntOne;
          end
        end
        TX_DATA: begin
          if (txCnt_q == BitLast) begin
            txCnt_q <= '0;
            if (txBit_q == 3'd7) begin
              host.uart_tx <= 1'b1;
              txState_q    <= TX_STOP;
            end else begin
              txBit_q      <= txBit_q + 3'd1;
              txShift_q    <= {1'b0, txShift_q[7:1]};
              host.uart_tx <= txShift_q[1];
            end
          end else begin
            txCnt_q <= txCnt_q + CntOne;
          end
        end
        TX_STOP: begin
          if (txCnt_q == BitLast) begin
            txCnt_q <= '0;
            if (txLeft_q == 4'd0) begin
              txState_q <= TX_IDLE;
              host.busy <= 1'b0;
            end else begin
              txState_q    <= TX_START;
              host.uart_tx <= 1'b0;
              txShift_q    <= txPkt_q[71:64];
              txPkt_q      <= {txPkt_q[63:0], 8'h00};
              txLeft_q     <= txLeft_q - 4'd1;
            end
          end else begin
            txCnt_q <= txCnt_q + CntOne;
            // Registered one cycle early so the pulse lands on the final stop-bit cycle.
            if (txLeft_q == 4'd0 && txCnt_q == BitPreLast) host.tx_done <= 1'b1;
          end
        end
      endcase
    end
  end

  logic rxMeta_q;
  logic rxSync_q;

  always_ff @(posedge clk_PSRAM) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= host.uart_rx;
      rxSync_q <= rxMeta_q;
    end
  end

  rxState_e        rxState_q;
  logic [CntW-1:0] rxCnt_q;
  logic [2:0]      rxBit_q;
  logic [7:0]      rxShift_q;
  logic            haveHi_q;
  logic [7:0]      hiByte_q;
  logic [ToW-1:0]  toCnt_q;

  // The timeout only runs while idle with a pending high byte; a started frame freezes it.
  always_ff @(posedge clk_PSRAM) begin
    if (rst) begin
      rxState_q          <= RX_IDLE;
      rxCnt_q            <= '0;
      rxBit_q            <= '0;
      rxShift_q          <= '0;
      haveHi_q           <= 1'b0;
      hiByte_q           <= '0;
      toCnt_q            <= '0;
      host.rx_word       <= '0;
      host.rx_word_valid <= 1'b0;
      host.rx_frame_err  <= 1'b0;
      host.rx_word_count <= '0;
    end else begin
      host.rx_word_valid <= 1'b0;
      host.rx_frame_err  <= 1'b0;
      if (haveHi_q && rxState_q == RX_IDLE) begin
        if (toCnt_q == ToLast) begin
          haveHi_q <= 1'b0;
          toCnt_q  <= '0;
        end else begin
          toCnt_q <= toCnt_q + ToOne;
        end
      end
      unique case (rxState_q)
        RX_IDLE: begin
          if (!rxSync_q) begin
            rxState_q <= RX_START;
            rxCnt_q   <= '0;
          end
        end
        RX_START: begin
          if (rxCnt_q == BitHalf) begin
            rxCnt_q <= '0;
            rxBit_q <= '0;
            rxState_q <= rxSync_q ? RX_IDLE : RX_DATA;
          end else begin
            rxCnt_q <= rxCnt_q + CntOne;
          end
        end
        RX_DATA: begin
          if (rxCnt_q == BitLast) begin
            rxCnt_q   <= '0;
            rxShift_q <= {rxSync_q, rxShift_q[7:1]};
            if (rxBit_q == 3'd7) rxState_q <= RX_STOP;
            else                 rxBit_q   <= rxBit_q + 3'd1;
          end else begin
            rxCnt_q <= rxCnt_q + CntOne;
          end
        end
        RX_STOP: begin
          if (rxCnt_q == BitLast) begin
            rxCnt_q   <= '0;
            rxState_q <= RX_IDLE;
            if (!rxSync_q) begin
              host.rx_frame_err <= 1'b1;
              haveHi_q          <= 1'b0;
            end else if (haveHi_q) begin
              host.rx_word       <= {hiByte_q, rxShift_q};
              host.rx_word_valid <= 1'b1;
              host.rx_word_count <= host.rx_word_count + 16'd1;
              haveHi_q           <= 1'b0;
            end else begin
              hiByte_q <= rxShift_q;
              haveHi_q <= 1'b1;
              toCnt_q  <= '0;
            end
          end else begin
            rxCnt_q <= rxCnt_q + CntOne;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/uart_cmd_host.md
Name: uart_cmd_host

Overview:
- Host-end counterpart of the acquisition UART link, used for on-chip loopback self-test and for a board-to-board controller.
- Serializes the acquisition command packet ('A' plus 9 config bytes) or the debug byte ('S') onto uart_tx.
- Receives the 2-byte response words on uart_rx and presents them as 16-bit words with a valid strobe.
- Same baud and framing as the acquisition link: 8N1, LSB first, bit period DELAY_FRAMES = (CLK*1_000_000)/UART_SPEED clocks (integer division; 65 at defaults).

Parameters:
CLK, 60, system clock frequency in MHz
UART_SPEED, 921600, baud rate in bit/s
TIMEOUT_BYTES, 4, response inter-byte timeout, in byte times (10*DELAY_FRAMES clocks each)

Ports:
clk_PSRAM  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
send_acq  input  1  1-cycle request to send the acquisition packet
send_debug  input  1  1-cycle request to send the debug byte 0x53
trigger  input  8  trigger type byte ('T' or 'B')
threshold  input  13  trigger threshold
samples_after  input  24  samples after trigger
samples_before  input  24  samples before trigger
uart_rx  input  1  serial in (response words from the acquisition side)
uart_tx  output  1  serial out (command packet)
busy  output  1  transmitter active
tx_done  output  1  1-cycle pulse when the last stop bit completes
rx_word  output  16  last received response word
rx_word_valid  output  1  1-cycle pulse when rx_word is updated
rx_frame_err  output  1  1-cycle pulse on a bad stop bit
rx_word_count  output  16  count of valid words received; wraps at 0xFFFF->0

Behaviour:
- Reset values: uart_tx=1, busy=0, tx_done=0, rx_word=0, rx_word_valid=0, rx_frame_err=0, rx_word_count=0. Both FSMs return to IDLE.
- Reset mid-operation: uart_tx=1 on the next cycle; any byte in flight is truncated; any partial response word is discarded.
- Request acceptance:
  - A request is accepted only in TX_IDLE with rst=0.
  - Requests arriving while busy=1 are ignored and are not queued.
  - If send_acq and send_debug are high together, send_acq wins.
  - All data inputs are latched in the accept cycle. Later changes do not affect the packet in flight.
  - busy rises the cycle after accept.
- Packet layout (bytes in order):
  - byte0 = 0x41
  - byte1 = trigger
  - byte2 = {3'b000, threshold[12:8]}
  - byte3 = threshold[7:0]
  - byte4..6 = samples_after[23:16], [15:8], [7:0]
  - byte7..9 = samples_before[23:16], [15:8], [7:0]
  - Debug packet is the single byte 0x53.
- TX FSM: TX_IDLE -> TX_START -> TX_DATA (8 bits) -> TX_STOP, then back to TX_START for the next byte, or to TX_IDLE after the last byte.
  - Each bit is held exactly DELAY_FRAMES cycles.
  - There is no idle gap between bytes.
  - Total length: acquisition packet = 100*DELAY_FRAMES cycles; debug packet = 10*DELAY_FRAMES cycles.
  - On the final stop-bit cycle, tx_done pulses and busy falls on the following cycle.
  - A new request can be accepted in the same cycle busy returns to 0.
- RX path: uart_rx passes through a 2-flop synchronizer; all decisions use the synchronized value.
- RX FSM: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP.
  - A low level in RX_IDLE starts RX_START.
  - The start bit is re-sampled at DELAY_FRAMES/2. If it is high, the event is a glitch and the FSM returns to RX_IDLE with no output.
  - Data bits are sampled every DELAY_FRAMES from the start-bit centre, LSB first.
  - Stop-bit sample = 1: byte accepted. Stop-bit sample = 0: rx_frame_err pulses, the byte is dropped and the partial word is cleared. In both cases the FSM returns to RX_IDLE.
- Word assembly:
  - The first accepted byte is the high byte and the second is the low byte.
  - On the second byte: rx_word <= {hi, lo}, rx_word_valid pulses, rx_word_count increments.
  - If the second byte has not started within TIMEOUT_BYTES*10*DELAY_FRAMES cycles after the first byte's stop sample, the high byte is discarded silently. The next byte is then treated as a high byte.
- TX and RX run independently; full-duplex operation is supported.

Test Plan:
- Acquisition packet: rst, then send_acq with trigger=0x54, threshold=0x1ABC, samples_after=0x000400, samples_before=0x000100 -> uart_tx decodes to 41 54 1A BC 00 04 00 00 01 00. The frame is 6500 cycles; tx_done is one pulse; busy is high for the whole frame.
- Simultaneous and overlapping requests: send_acq and send_debug in the same cycle -> only the 10-byte packet is sent. send_debug during busy -> ignored. send_debug after busy falls -> single byte 0x53 (650 cycles).
- Response words: drive uart_rx with bytes 0x12, 0x34, then 0xAB, 0xCD -> rx_word_valid pulses twice with 0x1234 then 0xABCD; rx_word_count=2.
- Frame error: send byte 0x12 with stop bit=0, then bytes 0x56, 0x78 -> one rx_frame_err pulse, then rx_word=0x5678 and rx_word_count=1.
- Glitch and timeout: a 20-cycle low glitch on uart_rx -> no output. Byte 0x99, then 2700 idle cycles, then 0x11, 0x22 -> rx_word=0x1122 only.
- Reset mid-frame: assert rst during byte4 of an acquisition packet -> next cycle uart_tx=1, busy=0, all counters cleared; a new send_acq then produces a complete, correct packet.
